// File: rtl/frequency_meter_gated_if.sv
// Register bus shared with the DSP blocks. Word-addressed, single-cycle strobes.
// Handshake: rd/wr are one-cycle strobes with addr/wdata valid alongside them; a mapped read answers with rvalid high for exactly one cycle after rd, with rdata valid alongside and rdata=0 otherwise; writes have no acknowledge and take effect at the next edge.
interface frequency_meter_gated_if #(
  parameter int ADDR_WIDTH = 12
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd;
  logic                  wr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  rvalid;

  modport master (output addr, rd, wr, wdata, input rdata, rvalid);
  modport slave  (input addr, rd, wr, wdata, output rdata, rvalid);
endinterface

// File: rtl/frequency_meter_gated.sv
// Multi-channel gated event-rate meter: per-channel strobe counts over a programmable
// window, with last/min/max capture and sticky out-of-range alarms.
module frequency_meter_gated #(
  parameter int          BASE_ADDR  = 0,
  parameter int          ADDR_WIDTH = 12,
  parameter int          CHANNELS   = 4,
  parameter int          CNT_W      = 24,
  parameter int          GATE_W     = 24,
  parameter logic [31:0] GATE_RST   = 32'(2**20 - 1)
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] strobe,
  frequency_meter_gated_if.slave bus,
  output logic                irq,
  output logic                gate_state
);
  localparam int NREG = 8 + 3 * CHANNELS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0] ID_VAL = (32'(NREG) << 16) | 32'h0000_1C41;
  localparam logic [31:0] GW = 32'(GATE_W);
  localparam logic [31:0] CW = 32'(CNT_W);
  localparam logic [31:0] CH = 32'(CHANNELS);
  localparam logic [31:0] PARAM_VAL = {GW[7:0], CW[7:0], CH[15:0]};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} gate_state_e;
  gate_state_e state_q, state_d;

  logic                ctrl_en_q, ctrl_en_d, irq_en_q;
  logic [GATE_W-1:0]   gate_q, gate_cnt_q;
  logic [CNT_W-1:0]    lo_q, hi_q;
  logic [CHANNELS-1:0] status_q, alarm_set;
  logic [31:0]         seq_q, rd_val;
  logic [CNT_W-1:0]    chan_cnt_q [CHANNELS];
  logic [CNT_W-1:0]    last_q     [CHANNELS];
  logic [CNT_W-1:0]    min_q      [CHANNELS];
  logic [CNT_W-1:0]    max_q      [CHANNELS];
  logic [CNT_W-1:0]    sample     [CHANNELS];
  logic                terminal, restart;

  logic [ADDR_WIDTH-1:0] off;
  logic mapped, wr_ctrl, wr_gate, wr_status, wr_lo, wr_hi, clr_minmax;
  logic unused_bits;

  assign off        = bus.addr - ADDR_WIDTH'(BASE_ADDR);
  assign mapped     = off < ADDR_WIDTH'(NREG);
  assign wr_ctrl    = bus.wr && (off == ADDR_WIDTH'(1));
  assign wr_gate    = bus.wr && (off == ADDR_WIDTH'(2));
  assign wr_status  = bus.wr && (off == ADDR_WIDTH'(3));
  assign wr_lo      = bus.wr && (off == ADDR_WIDTH'(5));
  assign wr_hi      = bus.wr && (off == ADDR_WIDTH'(6));
  assign clr_minmax = wr_ctrl && bus.wdata[2];
  assign unused_bits = ^bus.wdata;
  assign gate_state = (state_q == RUN);

  // RUN tracks the enable bit it will hold after this edge, so a window starts
  // on the first cycle after enable is written. A GATE write outranks a terminal cycle.
  always_comb begin
    ctrl_en_d = ctrl_en_q;
    if (wr_ctrl) ctrl_en_d = bus.wdata[0];
    state_d  = ctrl_en_d ? RUN : IDLE;
    terminal = (state_q == RUN) && (gate_cnt_q == gate_q) && !wr_gate;
    restart  = (state_d == IDLE) || wr_gate || terminal;
  end

  always_comb begin
    alarm_set = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sample[i] = (chan_cnt_q[i] == CNT_MAX) ? CNT_MAX : chan_cnt_q[i] + CNT_W'(strobe[i]);
      alarm_set[i] = terminal && ((sample[i] < lo_q) || (sample[i] > hi_q));
    end
  end

  always_comb begin
    rd_val = '0;
    case (off)
      ADDR_WIDTH'(0): rd_val = ID_VAL;
      ADDR_WIDTH'(1): rd_val = {30'd0, irq_en_q, ctrl_en_q};
      ADDR_WIDTH'(2): rd_val = 32'(gate_q);
      ADDR_WIDTH'(3): rd_val = 32'(status_q);
      ADDR_WIDTH'(4): rd_val = seq_q;
      ADDR_WIDTH'(5): rd_val = 32'(lo_q);
      ADDR_WIDTH'(6): rd_val = 32'(hi_q);
      ADDR_WIDTH'(7): rd_val = PARAM_VAL;
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (off == ADDR_WIDTH'(8 + 3 * i))  rd_val = 32'(last_q[i]);
          if (off == ADDR_WIDTH'(9 + 3 * i))  rd_val = 32'(min_q[i]);
          if (off == ADDR_WIDTH'(10 + 3 * i)) rd_val = 32'(max_q[i]);
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_en_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      gate_q     <= GATE_RST[GATE_W-1:0];
      gate_cnt_q <= '0;
      lo_q       <= '0;
      hi_q       <= '1;
      status_q   <= '0;
      seq_q      <= '0;
      irq        <= 1'b0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        chan_cnt_q[i] <= '0;
        last_q[i]     <= '0;
        min_q[i]      <= '1;
        max_q[i]      <= '0;
      end
    end else begin
      state_q   <= state_d;
      ctrl_en_q <= ctrl_en_d;
      if (wr_ctrl) irq_en_q <= bus.wdata[1];
      if (wr_gate) gate_q <= bus.wdata[GATE_W-1:0];
      if (wr_lo) lo_q <= bus.wdata[CNT_W-1:0];
      if (wr_hi) hi_q <= bus.wdata[CNT_W-1:0];
      // A fresh alarm overrides a same-cycle clear of that bit.
      status_q <= (wr_status ? (status_q & ~bus.wdata[CHANNELS-1:0]) : status_q) | alarm_set;
      irq      <= (|status_q) && irq_en_q;
      if (terminal) seq_q <= seq_q + 32'd1;
      if (restart) gate_cnt_q <= '0;
      else if (state_q == RUN) gate_cnt_q <= gate_cnt_q + GATE_W'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        if (restart) chan_cnt_q[i] <= '0;
        else if (state_q == RUN) chan_cnt_q[i] <= sample[i];
        if (terminal) last_q[i] <= sample[i];
        if (clr_minmax) begin
          min_q[i] <= terminal ? sample[i] : CNT_MAX;
          max_q[i] <= terminal ? sample[i] : '0;
        end else if (terminal) begin
          if (sample[i] < min_q[i]) min_q[i] <= sample[i];
          if (sample[i] > max_q[i]) max_q[i] <= sample[i];
        end
      end
      bus.rvalid <= bus.rd && mapped;
      bus.rdata  <= (bus.rd && mapped) ? rd_val : '0;
    end
  end
endmodule
